esl_mem_sample_logger: RTL and testbench

Upstream Avalon-MM master that streams 32-bit samples (encoder/tracker telemetry) into a circular region of the NIOS II on-chip memory through its second slave port. It also serves random-access readback of logged words for a debug/host path. It owns the write side of the region. The memory is single-port, 5120 × 32, with 1-cycle read latency.

---
 rtl/esl_logger_pkg.sv | 23 ++
 rtl/esl_logger_ring_ptr.sv | 79 +++++++
 rtl/esl_mem_sample_logger.sv | 192 +++++++++++++++++++
 tb/tb_esl_mem_sample_logger.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esl_logger_pkg.sv
// Shared definitions for the memory sample logger.
//   - state_t    : logger FSM states
//   - MEM_ADDR_W : on-chip memory word-address width
//   - MEM_WORDS  : on-chip memory depth in words
//   - DATA_W     : memory / sample word width
//   - BYTEEN_ALL : full-word byte enable
package esl_logger_pkg;

  localparam int MEM_ADDR_W = 13;
  localparam int MEM_WORDS  = 5120;
  localparam int DATA_W     = 32;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    WR_TS,
    WR_DATA,
    RD_ADDR,
    RD_WAIT
  } state_t;

endpackage

// File: rtl/esl_logger_ring_ptr.sv
// Ring bookkeeping for the sample logger.
//   Holds the write pointer, the fill level, the wrapped flag and the
//   saturating overflow counter. It also turns an oldest-relative index
//   into a physical ring offset.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : empties the ring and zeroes the statistics
//   wr_en        : one word is being written this cycle
//   index        : oldest-relative read index
//   wr_ptr       : next write offset, 0..DEPTH-1
//   fill_count   : valid words, saturates at DEPTH
//   wrapped      : ring has overwritten data since clear
//   overflow_cnt : overwritten words, saturating
//   phys_offset  : ring offset of the word at index
//   in_range     : index < fill_count
module esl_logger_ring_ptr
  import esl_logger_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        wr_en,
  input  logic [12:0] index,
  output logic [12:0] wr_ptr,
  output logic [13:0] fill_count,
  output logic        wrapped,
  output logic [15:0] overflow_cnt,
  output logic [12:0] phys_offset,
  output logic        in_range
);

  localparam logic [13:0] DEPTH_W  = 14'(DEPTH);
  localparam logic [12:0] LAST_PTR = 13'(DEPTH - 1);

  logic [12:0] wr_ptr_reg;
  logic [13:0] fill_count_reg;
  logic        wrapped_reg;
  logic [15:0] overflow_cnt_reg;

  logic [12:0] oldest;
  logic [13:0] sum;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg       <= '0;
      fill_count_reg   <= '0;
      wrapped_reg      <= 1'b0;
      overflow_cnt_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? 13'd0 : wr_ptr_reg + 13'd1;
      if (fill_count_reg < DEPTH_W) begin
        fill_count_reg <= fill_count_reg + 14'd1;
      end else begin
        wrapped_reg <= 1'b1;
        if (overflow_cnt_reg != 16'hFFFF) begin
          overflow_cnt_reg <= overflow_cnt_reg + 16'd1;
        end
      end
    end
  end

  // Once wrapped, the oldest word sits where the next write will land.
  // The sum is 14 bits wide so oldest+index cannot overflow before the
  // modulo; index < fill_count keeps it below 2*DEPTH.
  always_comb begin
    oldest      = wrapped_reg ? wr_ptr_reg : 13'd0;
    sum         = {1'b0, oldest} + {1'b0, index};
    phys_offset = (sum >= DEPTH_W) ? 13'(sum - DEPTH_W) : sum[12:0];
    in_range    = ({1'b0, index} < fill_count_reg);
  end

  assign wr_ptr       = wr_ptr_reg;
  assign fill_count   = fill_count_reg;
  assign wrapped      = wrapped_reg;
  assign overflow_cnt = overflow_cnt_reg;

endmodule

// File: rtl/esl_mem_sample_logger.sv
// Avalon-MM master that logs 32-bit samples into a circular region of a
// single-port on-chip memory and serves oldest-relative readback.
// Optional feature macro: ESL_LOGGER_TIMESTAMP_EN -- each sample is
// preceded by a free-running cycle-counter timestamp word.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   enable, clear           : logging permitted / empty ring + stats
//   snk_data/valid/ready    : sample stream input
//   rd_req, rd_index        : readback request, oldest-relative index
//   rd_valid/data/err       : readback response pulse
//   mem_*                   : memory port (1-cycle read latency)
//   wr_ptr, fill_count,
//   wrapped, overflow_cnt   : ring status
module esl_mem_sample_logger
  import esl_logger_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR = 13'd4096,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] snk_data,
  input  logic        snk_valid,
  output logic        snk_ready,
  input  logic        rd_req,
  input  logic [12:0] rd_index,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_err,
  output logic [12:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,
  output logic [12:0] wr_ptr,
  output logic [13:0] fill_count,
  output logic        wrapped,
  output logic [15:0] overflow_cnt
);

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   sample_reg;
  logic [12:0]         idx_reg;
  logic                rd_valid_reg;
  logic                rd_err_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic                ring_wr;
  logic [12:0]         phys_offset;
  logic                in_range;
  logic                accept;
`ifdef ESL_LOGGER_TIMESTAMP_EN
  logic [DATA_W-1:0]   ts_cnt_reg;
  logic [DATA_W-1:0]   ts_reg;
`endif

  // Reads win over samples; a sample is only taken in a quiet IDLE cycle.
  assign snk_ready = (state_reg == IDLE) & enable & ~clear & ~rd_req & ~reset;
  assign accept    = snk_valid & snk_ready;

  esl_logger_ring_ptr #(
    .DEPTH (DEPTH)
  ) u_ring_ptr (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .wr_en        (ring_wr),
    .index        (idx_reg),
    .wr_ptr       (wr_ptr),
    .fill_count   (fill_count),
    .wrapped      (wrapped),
    .overflow_cnt (overflow_cnt),
    .phys_offset  (phys_offset),
    .in_range     (in_range)
  );

`ifdef ESL_LOGGER_TIMESTAMP_EN
  // Free-running; deliberately untouched by clear.
  always_ff @(posedge clk) begin
    if (reset) ts_cnt_reg <= '0;
    else       ts_cnt_reg <= ts_cnt_reg + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      sample_reg   <= '0;
      idx_reg      <= '0;
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_data_reg  <= '0;
`ifdef ESL_LOGGER_TIMESTAMP_EN
      ts_reg       <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= 1'b0;
      if (state_reg == IDLE && !clear && rd_req) begin
        idx_reg <= rd_index;
      end
      if (accept) begin
        sample_reg <= snk_data;
`ifdef ESL_LOGGER_TIMESTAMP_EN
        ts_reg     <= ts_cnt_reg;
`endif
      end
      // A clear drops any read in flight without a response.
      if (!clear) begin
        if (state_reg == RD_ADDR && !in_range) begin
          rd_valid_reg <= 1'b1;
          rd_err_reg   <= 1'b1;
          rd_data_reg  <= '0;
        end else if (state_reg == RD_WAIT) begin
          rd_valid_reg <= 1'b1;
          rd_err_reg   <= 1'b0;
          rd_data_reg  <= mem_readdata;
        end
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = BASE_ADDR;
    mem_writedata  = '0;
    ring_wr        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!clear) begin
          if (rd_req) begin
            state_next = RD_ADDR;
          end else if (accept) begin
`ifdef ESL_LOGGER_TIMESTAMP_EN
            state_next = WR_TS;
`else
            state_next = WR_DATA;
`endif
          end
        end
      end
      WR_TS: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = BASE_ADDR + wr_ptr;
`ifdef ESL_LOGGER_TIMESTAMP_EN
        mem_writedata  = ts_reg;
`endif
        ring_wr        = 1'b1;
        state_next     = WR_DATA;
      end
      WR_DATA: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = BASE_ADDR + wr_ptr;
        mem_writedata  = sample_reg;
        ring_wr        = 1'b1;
        state_next     = IDLE;
      end
      RD_ADDR: begin
        if (in_range) begin
          mem_chipselect = 1'b1;
          mem_address    = BASE_ADDR + phys_offset;
          state_next     = RD_WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Clear wins in every state: no memory strobe, no ring update.
    if (clear || reset) begin
      state_next     = IDLE;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      ring_wr        = 1'b0;
    end
  end

  assign rd_valid       = rd_valid_reg;
  assign rd_err         = rd_err_reg;
  assign rd_data        = rd_data_reg;
  assign mem_byteenable = BYTEEN_ALL;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_esl_mem_sample_logger.sv
// Self-checking bench for esl_mem_sample_logger (DEPTH=8, BASE_ADDR=100).
// Reference model: a queue of every word logged since the last clear;
// ring status and readback values are derived from its length.
module tb_esl_mem_sample_logger;

  localparam int          DEPTH = 8;
  localparam logic [12:0] BASE  = 13'd100;
`ifdef ESL_LOGGER_TIMESTAMP_EN
  localparam int WPS = 2;
`else
  localparam int WPS = 1;
`endif

  logic        clk, reset, enable, clear;
  logic [31:0] snk_data;
  logic        snk_valid, snk_ready;
  logic        rd_req;
  logic [12:0] rd_index;
  logic        rd_valid, rd_err;
  logic [31:0] rd_data;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic [12:0] wr_ptr;
  logic [13:0] fill_count;
  logic        wrapped;
  logic [15:0] overflow_cnt;

  esl_mem_sample_logger #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .rd_req(rd_req), .rd_index(rd_index),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .wr_ptr(wr_ptr), .fill_count(fill_count), .wrapped(wrapped),
    .overflow_cnt(overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with 1-cycle read latency.
  logic [31:0] mem_model [0:8191];
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) mem_model[mem_address] <= mem_writedata;
    mem_readdata <= mem_model[mem_address];
  end

  // Cycle count since reset release: the expected timestamp value.
  logic [31:0] cyc;
  always @(posedge clk) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         pend[$];
  logic [31:0] hist[$];
  int          n_words;
  int          rd_cs_cnt;
  int          n_cmp, n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_push(input logic [31:0] w);
    wr_t e;
    e.addr = 32'(BASE) + 32'(n_words % DEPTH);
    e.data = w;
    pend.push_back(e);
    hist.push_back(w);
    n_words++;
  endtask

  task automatic model_clear();
    pend.delete();
    hist.delete();
    n_words = 0;
  endtask

  // Memory write monitor: each write must match the next expected word.
  always @(negedge clk) begin
    if (!reset) begin
      if (clear) check_val("clear_gates_write", 32'(mem_write), 32'd0);
      if (mem_chipselect && mem_write) begin
        if (pend.size() == 0) begin
          check_val("write_expected", 32'(mem_write), 32'd0);
        end else begin
          wr_t e;
          e = pend.pop_front();
          check_val("wr_addr", 32'(mem_address), e.addr);
          check_val("wr_data", mem_writedata, e.data);
        end
      end
      if (mem_chipselect && !mem_write) rd_cs_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int exp_fill();
    return (n_words < DEPTH) ? n_words : DEPTH;
  endfunction

  task automatic check_status();
    int ov;
    ov = (n_words > DEPTH) ? n_words - DEPTH : 0;
    if (ov > 65535) ov = 65535;
    check_val("wr_ptr", 32'(wr_ptr), 32'(n_words % DEPTH));
    check_val("fill_count", 32'(fill_count), 32'(exp_fill()));
    check_val("wrapped", 32'(wrapped), 32'(n_words > DEPTH));
    check_val("overflow_cnt", 32'(overflow_cnt), 32'(ov));
  endtask

  // Called at the negedge of the accept cycle (valid & ready seen).
  task automatic accept_tail(input logic [31:0] d, input logic drop_enable);
`ifdef ESL_LOGGER_TIMESTAMP_EN
    model_push(cyc);
`endif
    model_push(d);
    @(posedge clk); #1;
    snk_valid = 1'b0;
    if (drop_enable) enable = 1'b0;
    repeat (WPS) tick();
    check_val("pend_drained", 32'(pend.size()), 32'd0);
    $display("sample 0x%08h logged, words=%0d", d, n_words);
  endtask

  task automatic send(input logic [31:0] d, input logic drop_enable);
    int waited;
    waited = 0;
    snk_valid = 1'b1;
    snk_data  = d;
    @(negedge clk);
    while (!snk_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_val("snk_ready", 32'(snk_ready), 32'd1);
    accept_tail(d, drop_enable);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_clear();
    tick();
    clear = 1'b0;
    $display("clear");
  endtask

  // Readback; optionally offers a sample in the same cycle as rd_req.
  task automatic do_read(input int idx, input logic with_sample, input logic [31:0] d);
    int lat, cs0, fill;
    logic        exp_err;
    logic [31:0] exp_data;
    fill     = exp_fill();
    exp_err  = (idx >= fill);
    exp_data = exp_err ? 32'd0 : hist[hist.size() - fill + idx];
    cs0      = rd_cs_cnt;
    rd_req   = 1'b1;
    rd_index = 13'(idx);
    if (with_sample) begin
      snk_valid = 1'b1;
      snk_data  = d;
    end
    @(negedge clk);
    if (with_sample) check_val("ready_low_on_rd", 32'(snk_ready), 32'd0);
    @(posedge clk); #1;
    rd_req = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (rd_valid || lat >= 8) break;
      @(posedge clk); #1;
      lat++;
    end
    check_val("rd_latency", 32'(lat), exp_err ? 32'd2 : 32'd3);
    check_val("rd_err", 32'(rd_err), 32'(exp_err));
    check_val("rd_data", rd_data, exp_data);
    check_val("rd_cs_count", 32'(rd_cs_cnt - cs0), exp_err ? 32'd0 : 32'd1);
    $display("read idx=%0d data=0x%08h err=%0d lat=%0d", idx, rd_data, rd_err, lat);
    if (with_sample) begin
      check_val("ready_after_rd", 32'(snk_ready), 32'd1);
      accept_tail(d, 1'b0);
    end else begin
      tick();
    end
  endtask

  initial begin
    int seen, r;
    n_cmp = 0; n_err = 0; n_words = 0; rd_cs_cnt = 0;
    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    snk_data = '0; snk_valid = 1'b0; rd_req = 1'b0; rd_index = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_snk_ready", 32'(snk_ready), 32'd0);
    check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_val("rst_rd_err", 32'(rd_err), 32'd0);
    check_val("rst_rd_data", rd_data, 32'd0);
    check_val("rst_cs", 32'(mem_chipselect), 32'd0);
    check_val("rst_wr", 32'(mem_write), 32'd0);
    check_val("rst_addr", 32'(mem_address), 32'(BASE));
    check_val("rst_wdata", mem_writedata, 32'd0);
    check_val("byteenable", 32'(mem_byteenable), 32'hF);
    check_val("clken", 32'(mem_clken), 32'd1);
    check_status();
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset released");

    // Three samples, then an out-of-range read.
    for (int i = 0; i < 3; i++) send(32'hA0 + 32'(i), 1'b0);
    check_status();
    do_read(exp_fill() + 2, 1'b0, 32'd0);
    do_read(0, 1'b0, 32'd0);

    // Wrap the ring: ten samples.
    do_clear();
    check_status();
    for (int i = 0; i < 10; i++) send(32'(i), 1'b0);
    check_status();
    do_read(0, 1'b0, 32'd0);
    do_read(DEPTH - 1, 1'b0, 32'd0);
    do_read(DEPTH, 1'b0, 32'd0);

    // Read and sample offered together.
    do_read(3, 1'b1, 32'hBEEF_0001);
    check_status();

    // Clear during the final write cycle of a sample.
    snk_valid = 1'b1;
    snk_data  = 32'hDEAD_0001;
    @(negedge clk);
    check_val("snk_ready_pre_clr", 32'(snk_ready), 32'd1);
`ifdef ESL_LOGGER_TIMESTAMP_EN
    model_push(cyc);
`endif
    model_push(snk_data);
    @(posedge clk); #1;
    snk_valid = 1'b0;
    repeat (WPS - 1) tick();
    do_clear();
    @(negedge clk);
    check_status();
    check_val("idle_after_clr", 32'(snk_ready), 32'd1);
    @(posedge clk); #1;

    // Clear while a read is waiting on memory: no response.
    for (int i = 0; i < 4; i++) send(32'h1000 + 32'(i), 1'b0);
    rd_req = 1'b1; rd_index = 13'd1;
    tick();
    rd_req = 1'b0;
    tick();
    do_clear();
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rd_valid) seen++;
      @(posedge clk); #1;
    end
    check_val("read_dropped", 32'(seen), 32'd0);
    check_status();

    // Enable dropped right after accept: the write still completes.
    send(32'h5A5A_5A5A, 1'b1);
    @(negedge clk);
    check_val("ready_disabled", 32'(snk_ready), 32'd0);
    check_status();
    @(posedge clk); #1;
    enable = 1'b1;

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 3));
      if (r <= 1)      send($urandom, 1'b0);
      else if (r == 2) do_read(int'($urandom_range(0, DEPTH + 2)), ($urandom_range(0, 3) == 0), $urandom);
      else             check_status();
    end
    check_status();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
